// File: rtl/traffic_ctrl_if.sv
// Control inputs and display/lamp outputs of the two-way traffic sequencer.
// slave is the sequencer side; master is the side that drives modes and reads the display.
interface traffic_ctrl_if;
  logic       emergency;
  logic       night_mode;
  logic [7:0] data;
  logic [7:0] data2;
  logic       enable;
  logic [2:0] light_a;
  logic [2:0] light_b;

  modport slave (
    input  emergency,
    input  night_mode,
    output data,
    output data2,
    output enable,
    output light_a,
    output light_b
  );

  modport master (
    output emergency,
    output night_mode,
    input  data,
    input  data2,
    input  enable,
    input  light_a,
    input  light_b
  );
endinterface

// File: rtl/traffic_ctrl.sv
// Two-way green/yellow/red sequencer with per-direction countdown, all-red hold and flashing night mode.
// Outputs decode combinationally from the registered state/count; emergency lamp override has zero latency.
module traffic_ctrl #(
  parameter int GREEN_T  = 25,
  parameter int YELLOW_T = 5
) (
  input  logic          clk_divide,
  input  logic          rst_n,
  traffic_ctrl_if.slave tc
);

  typedef enum logic [2:0] {
    AG_BR = 3'd0,
    AY_BR = 3'd1,
    AR_BG = 3'd2,
    AR_BY = 3'd3,
    NIGHT = 3'd4
  } state_t;

  localparam logic [6:0] GREEN_LD   = 7'(GREEN_T);
  localparam logic [6:0] YELLOW_LD  = 7'(YELLOW_T);
  localparam logic [7:0] YELLOW_ADD = 8'(YELLOW_T);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_cnt;
  logic [6:0] w_cnt_nxt;
  logic       r_flash;
  logic       w_flash_nxt;

  logic [7:0] w_cnt_ext;
  logic [7:0] w_cnt_plus_y;
  logic [7:0] w_data;
  logic [7:0] w_data2;
  logic       w_enable;
  logic [2:0] w_light_a;
  logic [2:0] w_light_b;

  // rst_n is active-high despite its name, inherited from the surrounding codebase.
  always_ff @(posedge clk_divide or posedge rst_n) begin
    if (rst_n) begin
      r_state <= AG_BR;
      r_cnt   <= GREEN_LD;
      r_flash <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flash <= w_flash_nxt;
    end
  end

  // Parameter limits keep GREEN_T+YELLOW_T within 99, so 8 bits never overflow.
  assign w_cnt_ext    = {1'b0, r_cnt};
  assign w_cnt_plus_y = w_cnt_ext + YELLOW_ADD;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flash_nxt = r_flash;
    w_data      = w_cnt_ext;
    w_data2     = w_cnt_ext;
    w_enable    = 1'b1;
    w_light_a   = 3'b100;
    w_light_b   = 3'b100;

    // Hold beats night entry, and both beat a phase change on the same edge.
    if (tc.emergency) begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_flash_nxt = r_flash;
    end else if (tc.night_mode) begin
      w_state_nxt = NIGHT;
      w_flash_nxt = (r_state == NIGHT) ? ~r_flash : 1'b1;
    end else if (r_state == NIGHT) begin
      w_state_nxt = AG_BR;
      w_cnt_nxt   = GREEN_LD;
      w_flash_nxt = 1'b0;
    end else if (r_cnt > 7'd1) begin
      w_cnt_nxt = r_cnt - 7'd1;
    end else begin
      case (r_state)
        AG_BR: begin
          w_state_nxt = AY_BR;
          w_cnt_nxt   = YELLOW_LD;
        end
        AY_BR: begin
          w_state_nxt = AR_BG;
          w_cnt_nxt   = GREEN_LD;
        end
        AR_BG: begin
          w_state_nxt = AR_BY;
          w_cnt_nxt   = YELLOW_LD;
        end
        AR_BY: begin
          w_state_nxt = AG_BR;
          w_cnt_nxt   = GREEN_LD;
        end
        default: begin
          w_state_nxt = AG_BR;
          w_cnt_nxt   = GREEN_LD;
        end
      endcase
    end

    case (r_state)
      AG_BR: begin
        w_data2   = w_cnt_plus_y;
        w_light_a = 3'b001;
        w_light_b = 3'b100;
      end
      AY_BR: begin
        w_light_a = 3'b010;
        w_light_b = 3'b100;
      end
      AR_BG: begin
        w_data    = w_cnt_plus_y;
        w_light_a = 3'b100;
        w_light_b = 3'b001;
      end
      AR_BY: begin
        w_light_a = 3'b100;
        w_light_b = 3'b010;
      end
      NIGHT: begin
        w_data    = 8'd0;
        w_data2   = 8'd0;
        w_enable  = 1'b0;
        w_light_a = {1'b0, r_flash, 1'b0};
        w_light_b = {1'b0, r_flash, 1'b0};
      end
      default: begin
        w_light_a = 3'b100;
        w_light_b = 3'b100;
      end
    endcase

    if (tc.emergency) begin
      w_light_a = 3'b100;
      w_light_b = 3'b100;
    end
  end

  assign tc.data    = w_data;
  assign tc.data2   = w_data2;
  assign tc.enable  = w_enable;
  assign tc.light_a = w_light_a;
  assign tc.light_b = w_light_b;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl: expected display/lamp words are queued as stimulus is driven
// and popped for comparison after each edge (or after a settle delay for combinational effects).
module tb_traffic_ctrl;

  localparam int G = 25;
  localparam int Y = 5;

  typedef struct {
    string       tag;
    logic [22:0] v;
  } exp_t;

  logic clk_divide;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   p;
  exp_t sb[$];

  traffic_ctrl_if tc_if ();

  traffic_ctrl #(
    .GREEN_T  (G),
    .YELLOW_T (Y)
  ) dut (
    .clk_divide (clk_divide),
    .rst_n      (rst_n),
    .tc         (tc_if)
  );

  initial begin
    clk_divide = 1'b0;
    forever #5 clk_divide = ~clk_divide;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(string tag, int d, int d2, logic en, logic [2:0] la, logic [2:0] lb);
    exp_t x;
    x.tag = tag;
    x.v   = {8'(d), 8'(d2), en, la, lb};
    return x;
  endfunction

  // Normal-cycle display for edge count p since an AG_BR phase start with full green.
  function automatic exp_t normal(int pos);
    int q;
    int c;
    q = pos % (2 * (G + Y));
    if (q < G) begin
      c = G - q;
      return mk("ag_br", c, c + Y, 1'b1, 3'b001, 3'b100);
    end else if (q < G + Y) begin
      c = Y - (q - G);
      return mk("ay_br", c, c, 1'b1, 3'b010, 3'b100);
    end else if (q < 2 * G + Y) begin
      c = G - (q - G - Y);
      return mk("ar_bg", c + Y, c, 1'b1, 3'b100, 3'b001);
    end else begin
      c = Y - (q - 2 * G - Y);
      return mk("ar_by", c, c, 1'b1, 3'b100, 3'b010);
    end
  endfunction

  task automatic compare();
    exp_t        x;
    logic [22:0] obs;
    x   = sb.pop_front();
    obs = {tc_if.data, tc_if.data2, tc_if.enable, tc_if.light_a, tc_if.light_b};
    n_checks++;
    assert (obs === x.v) else begin
      n_fail++;
      $error("FAIL %s: observed data=%0d data2=%0d en=%b a=%b b=%b, expected data=%0d data2=%0d en=%b a=%b b=%b",
             x.tag, obs[22:15], obs[14:7], obs[6], obs[5:3], obs[2:0],
             x.v[22:15], x.v[14:7], x.v[6], x.v[5:3], x.v[2:0]);
    end
  endtask

  task automatic step(exp_t x);
    sb.push_back(x);
    @(posedge clk_divide);
    #1;
    compare();
  endtask

  task automatic check_now(exp_t x);
    sb.push_back(x);
    #1;
    compare();
  endtask

  task automatic step_normal();
    p++;
    step(normal(p));
  endtask

  task automatic run_to(int target);
    while ((p % (2 * (G + Y))) != target) step_normal();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    p        = 0;
    rst_n    = 1'b0;
    tc_if.emergency  = 1'b0;
    tc_if.night_mode = 1'b0;

    #1 rst_n = 1'b1;
    check_now(mk("reset", 25, 30, 1'b1, 3'b001, 3'b100));
    rst_n = 1'b0;

    // Full normal cycle, ending back at AG_BR with 25.
    for (int e = 0; e < 60; e++) step_normal();

    // All-red hold at AR_BG count 12.
    run_to(43);
    tc_if.emergency = 1'b1;
    check_now(mk("emg_on", 17, 12, 1'b1, 3'b100, 3'b100));
    for (int e = 0; e < 7; e++) step(mk("emg_hold", 17, 12, 1'b1, 3'b100, 3'b100));
    tc_if.emergency = 1'b0;
    check_now(mk("emg_off", 17, 12, 1'b1, 3'b100, 3'b001));
    step_normal();

    // Hold coinciding with the last yellow tick of A.
    run_to(29);
    tc_if.emergency = 1'b1;
    check_now(mk("emg_cnt1", 1, 1, 1'b1, 3'b100, 3'b100));
    for (int e = 0; e < 2; e++) step(mk("emg_cnt1_hold", 1, 1, 1'b1, 3'b100, 3'b100));
    tc_if.emergency = 1'b0;
    check_now(mk("emg_cnt1_off", 1, 1, 1'b1, 3'b010, 3'b100));
    step_normal();

    // Night mode entered mid-green.
    run_to(10);
    tc_if.night_mode = 1'b1;
    step(mk("night1", 0, 0, 1'b0, 3'b010, 3'b010));
    step(mk("night2", 0, 0, 1'b0, 3'b000, 3'b000));
    step(mk("night3", 0, 0, 1'b0, 3'b010, 3'b010));
    step(mk("night4", 0, 0, 1'b0, 3'b000, 3'b000));
    tc_if.night_mode = 1'b0;
    step(mk("night_exit", 25, 30, 1'b1, 3'b001, 3'b100));
    p = 0;

    // Emergency inside night mode freezes the flash.
    tc_if.night_mode = 1'b1;
    step(mk("nemg_enter", 0, 0, 1'b0, 3'b010, 3'b010));
    tc_if.emergency = 1'b1;
    check_now(mk("nemg_on", 0, 0, 1'b0, 3'b100, 3'b100));
    for (int e = 0; e < 2; e++) step(mk("nemg_hold", 0, 0, 1'b0, 3'b100, 3'b100));
    tc_if.emergency = 1'b0;
    check_now(mk("nemg_off", 0, 0, 1'b0, 3'b010, 3'b010));
    step(mk("nemg_flash0", 0, 0, 1'b0, 3'b000, 3'b000));
    step(mk("nemg_flash1", 0, 0, 1'b0, 3'b010, 3'b010));
    tc_if.night_mode = 1'b0;
    step(mk("nemg_exit", 25, 30, 1'b1, 3'b001, 3'b100));
    p = 0;

    // Asynchronous reset mid AR_BY at count 3.
    run_to(57);
    rst_n = 1'b1;
    check_now(mk("rst_async", 25, 30, 1'b1, 3'b001, 3'b100));
    step(mk("rst_held", 25, 30, 1'b1, 3'b001, 3'b100));
    rst_n = 1'b0;
    p = 0;
    for (int e = 0; e < 6; e++) step_normal();

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending entries, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Two-way traffic-light sequencer that produces the countdown values consumed by the intersection's seven-segment display driver. It runs the green → yellow → red cycle for direction A and direction B, and drives both lamp sets. It presents the seconds remaining for each direction on `data`/`data2` (0–99, binary) together with the display `enable`. It also supports an all-red emergency hold and a flashing-yellow night mode. One `clk_divide` rising edge equals one second.

## Interface
Parameters:
- `GREEN_T`, default 25: green duration in ticks. Legal range is 1..94.
- `YELLOW_T`, default 5: yellow duration in ticks. Legal range is 1..(99−GREEN_T), so that `GREEN_T+YELLOW_T` ≤ 99.

Ports:
- `clk_divide`  in  1  1 Hz divided clock; all state changes on its rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-high.
- `emergency`  in  1  High: all-red hold, countdown frozen. Priority over `night_mode`.
- `night_mode`  in  1  High: flashing-yellow mode, display blanked.
- `data`  out  8  Seconds until direction A's lamp changes; 0 in night mode.
- `data2`  out  8  Seconds until direction B's lamp changes; 0 in night mode.
- `enable`  out  1  Display enable; 0 only in night mode.
- `light_a`  out  3  Direction A lamps {red, yellow, green}, one-hot or 000.
- `light_b`  out  3  Direction B lamps {red, yellow, green}, one-hot or 000.

## Operation
- State register has five states: AG_BR, AY_BR, AR_BG, AR_BY, NIGHT.
- Phase counter `cnt` is 7 bits and holds the remaining ticks of the current phase.
- Auxiliary 1-bit `flash` register.
- Normal sequence: AG_BR (`GREEN_T`) → AY_BR (`YELLOW_T`) → AR_BG (`GREEN_T`) → AR_BY (`YELLOW_T`) → AG_BR.
- Countdown per edge, when `emergency`=0 and `night_mode`=0:
  - if `cnt` > 1: decrement `cnt`;
  - if `cnt` = 1: advance to the next state and load that phase's duration.
- Each phase therefore lasts exactly its duration, and the display shows T down to 1.
- Output decode (combinational from registered state and `cnt`):
  - AG_BR: `data`=`cnt`, `data2`=`cnt`+`YELLOW_T`; `light_a`=001, `light_b`=100.
  - AY_BR: `data`=`data2`=`cnt`; `light_a`=010, `light_b`=100.
  - AR_BG: `data`=`cnt`+`YELLOW_T`, `data2`=`cnt`; `light_a`=100, `light_b`=001.
  - AR_BY: `data`=`data2`=`cnt`; `light_a`=100, `light_b`=010.
  - NIGHT: `data`=`data2`=0, `enable`=0, `light_a`=`light_b`={0,`flash`,0}.
- Arithmetic:
  - `cnt`+`YELLOW_T` is computed at 8 bits, zero-extended.
  - The parameter limits guarantee the result is ≤ 99, so there is no overflow path.
- Emergency (`emergency`=1, sampled each edge):
  - state, `cnt` and `flash` are held;
  - `light_a`=`light_b`=100 immediately, as a combinational override;
  - `data`/`data2` show the frozen values, `enable`=1 (in NIGHT, 0/0 and `enable`=0 remain).
  - On release, countdown resumes from the frozen `cnt` at the next edge. The phase is not restarted.
- Night entry: `night_mode`=1 with `emergency`=0 at an edge moves to NIGHT from any state. `flash` is loaded to 1 and `cnt` is don't-care.
- In NIGHT, `flash` toggles every edge.
- Night exit: `night_mode`=0 at an edge in NIGHT moves to AG_BR with `cnt`=`GREEN_T` and `flash`=0.
- Simultaneous events:
  - `cnt`=1 with `emergency` rising on the same edge: hold wins, and the phase does not advance.
  - `cnt`=1 with `night_mode`: NIGHT wins.

## Timing
- Reset values (asynchronous, immediate):
  - state AG_BR, `cnt`=`GREEN_T`, `flash`=0;
  - hence `data`=25, `data2`=30, `enable`=1, `light_a`=001, `light_b`=100 (defaults).
- Reset asserted mid-phase returns to these values at once. The first decrement occurs on the first edge after `rst_n` falls.
- Output latency: outputs reflect a state/`cnt` update in the same cycle it is registered. There is no extra pipeline stage.
- `emergency` lamp override is combinational, with zero latency. Counter freeze takes effect from the first edge at which it is sampled high.
- Full normal cycle is 2×(`GREEN_T`+`YELLOW_T`) = 60 edges with defaults.
- Inputs are assumed synchronous to `clk_divide`; no internal synchronizer.

## Test plan
- Reset, then 60 edges → 25..1 in AG_BR (`data2` 30..6), 5..1 in AY_BR (`data2` 5..1), AR_BG 30..6/25..1, AR_BY 5..1/5..1; back to AG_BR `data`=25 at edge 60.
- Assert `emergency` at `cnt`=12 in AR_BG for 7 edges → lamps 100/100, `data`=17 and `data2`=12 frozen; after release, next edge gives `data2`=11.
- `emergency` and `cnt`=1 coincide in AY_BR → state stays AY_BR, `data`=1; one edge after release → AR_BG, `data2`=25.
- `night_mode`=1 mid-AG_BR for 4 edges → `enable`=0, `data`=`data2`=0, yellow lamps 010,000,010,000; drop `night_mode` → AG_BR, `data`=25, `data2`=30, `enable`=1.
- `emergency` during NIGHT → lamps 100/100, `flash` frozen, `enable` stays 0; release resumes flashing.
- Pulse `rst_n` high mid-AR_BY with `cnt`=3 → outputs immediately 25/30/001/100; countdown restarts on the next edge after release.
